// File: rtl/mmio_arb_pkg.sv
// Shared definitions for the two-port MMIO arbiter: FSM encoding, port indices
// and the value returned to a master when a read is aborted by timeout.
package mmio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam logic [7:0] ERR_RDATA = 8'hFF;

endpackage

// File: rtl/mmio_rr_pick.sv
// Two-way round-robin pick: a lone requester wins outright, on contention the
// port that did not own the last transaction wins.
module mmio_rr_pick
  import mmio_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic owner,
  output logic valid,
  output logic grant
);

  assign valid = req0 | req1;
  assign grant = (req0 && req1) ? ~owner : (req1 ? PORT_AUX : PORT_CPU);

endmodule

// File: rtl/mmio_arbiter.sv
// Serialises CPU (port 0) and auxiliary (port 1) accesses onto the peripheral bus.
// Optional stall timeout with error reporting under MMIO_ARB_TIMEOUT_EN.
module mmio_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              bus_re,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_stall,
  output logic              busy,
  output logic              owner
);

  arb_state_e             state;
  logic                   pick_valid;
  logic                   pick_grant;
  logic                   sel_we;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic                   cur_we;
  logic                   timeout_hit;
  logic                   timed_out;
  logic [1:0]             ack_q;
  logic [1:0][DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0]      resp_data;

  mmio_rr_pick u_pick (
    .req0  (req0),
    .req1  (req1),
    .owner (owner),
    .valid (pick_valid),
    .grant (pick_grant)
  );

  assign sel_we    = pick_grant ? we1    : we0;
  assign sel_addr  = pick_grant ? addr1  : addr0;
  assign sel_wdata = pick_grant ? wdata1 : wdata0;

`ifdef MMIO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       err_q;

  // Fires on the TIMEOUT-th consecutive stalled strobe cycle.
  assign timeout_hit = (state == ISSUE) && bus_stall &&
                       (stall_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      err_q     <= '0;
      timed_out <= 1'b0;
    end else if (state == IDLE) begin
      if (pick_valid) stall_cnt <= '0;
    end else if (state == ISSUE) begin
      if (bus_stall && !timeout_hit) begin
        stall_cnt <= stall_cnt + 1'b1;
      end else begin
        err_q[owner] <= timeout_hit;
        timed_out    <= timeout_hit;
      end
    end
  end

  assign err0 = err_q[0];
  assign err1 = err_q[1];
`else
  logic [$clog2(TIMEOUT + 1)-1:0] unused_timeout;
  assign unused_timeout = '0;
  assign timeout_hit    = 1'b0;
  assign timed_out      = 1'b0;
  assign err0           = 1'b0;
  assign err1           = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= PORT_AUX;
      cur_we    <= 1'b0;
      bus_re    <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
    end else begin
      ack_q <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick_grant;
            cur_we    <= sel_we;
            bus_addr  <= sel_addr;
            bus_wdata <= sel_wdata;
            bus_re    <= ~sel_we;
            bus_we    <= sel_we;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!bus_stall || timeout_hit) begin
            bus_re       <= 1'b0;
            bus_we       <= 1'b0;
            ack_q[owner] <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (!cur_we) rdata_q[owner] <= resp_data;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The bus presents read data one cycle after the strobe, i.e. during RESP,
  // so the acked port sees it directly and the register holds it afterwards.
  assign resp_data = timed_out ? '1 : bus_rdata;
  assign rdata0    = (ack_q[0] && !cur_we) ? resp_data : rdata_q[0];
  assign rdata1    = (ack_q[1] && !cur_we) ? resp_data : rdata_q[1];
  assign ack0      = ack_q[0];
  assign ack1      = ack_q[1];
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mmio_arbiter.sv
// Self-checking bench for mmio_arbiter: directed scenarios plus randomized
// traffic checked every cycle against a transaction-level model.
module tb_mmio_arbiter;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic req0, req1, we0, we1;
  logic [14:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic ack0, ack1, err0, err1;
  logic [7:0] rdata0, rdata1;
  logic bus_re, bus_we, bus_stall, busy, owner;
  logic [14:0] bus_addr;
  logic [7:0] bus_wdata, bus_rdata;

  logic [1:0] reqv, wev;
  logic [1:0][14:0] addrv;
  logic [1:0][7:0] wdatav;
  assign req0 = reqv[0];  assign req1 = reqv[1];
  assign we0 = wev[0];    assign we1 = wev[1];
  assign addr0 = addrv[0]; assign addr1 = addrv[1];
  assign wdata0 = wdatav[0]; assign wdata1 = wdatav[1];

  always #5 clk = ~clk;

  mmio_arbiter #(.ADDR_W(15), .DATA_W(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .bus_re(bus_re), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_stall(bus_stall), .busy(busy), .owner(owner)
  );

  function automatic logic [7:0] rfun(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'hC0;
  endfunction

  // Peripheral: registered read data, one cycle after the read strobe.
  always @(posedge clk) if (bus_re) bus_rdata <= rfun(bus_addr);

  int vectors = 0, miscompares = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { int c; bit p; logic [7:0] rd; logic er; } ack_t;
  ack_t alog[$];
  logic [1:0] ack_seen = '0;
  int we_cnt = 0, re_run = 0, re_max = 0;
  logic [14:0] we_addr = '0;
  logic [7:0] we_data = '0;

  // Reference model: one transaction in flight, strobe until the bus stops stalling.
  bit m_act, m_strobe, m_to, m_p, m_we, m_owner;
  logic [14:0] m_addr;
  logic [7:0] m_wdata;
  int m_stalls;
  logic [7:0] m_rd[2];
  logic m_er[2];

  task automatic model_reset();
    m_act = 0; m_strobe = 0; m_to = 0; m_p = 0; m_we = 0; m_owner = 1;
    m_addr = '0; m_wdata = '0; m_stalls = 0;
    m_rd[0] = '0; m_rd[1] = '0; m_er[0] = 0; m_er[1] = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) model_reset();
      if (m_act && !m_strobe) begin
        if (!m_we) m_rd[m_p] = m_to ? 8'hFF : rfun(m_addr);
        m_er[m_p] = m_to;
      end
      chk("bus_re", bus_re, m_act && m_strobe && !m_we);
      chk("bus_we", bus_we, m_act && m_strobe && m_we);
      chk("bus_addr", bus_addr, m_addr);
      chk("bus_wdata", bus_wdata, m_wdata);
      chk("ack0", ack0, m_act && !m_strobe && !m_p);
      chk("ack1", ack1, m_act && !m_strobe && m_p);
      chk("rdata0", rdata0, m_rd[0]);
      chk("rdata1", rdata1, m_rd[1]);
      chk("err0", err0, m_er[0]);
      chk("err1", err1, m_er[1]);
      chk("busy", busy, m_act);
      chk("owner", owner, m_owner);
      // monitor for directed checks
      ack_seen = {ack1, ack0};
      if (ack0) alog.push_back('{c: cyc, p: 1'b0, rd: rdata0, er: err0});
      if (ack1) alog.push_back('{c: cyc, p: 1'b1, rd: rdata1, er: err1});
      if (bus_we) begin we_cnt++; we_addr = bus_addr; we_data = bus_wdata; end
      re_run = bus_re ? re_run + 1 : 0;
      if (re_run > re_max) re_max = re_run;
      // advance the model to the next cycle
      if (reset_n) begin
        if (!m_act) begin
          if (reqv != 2'b00) begin
            m_p = (reqv[0] && reqv[1]) ? !m_owner : reqv[1];
            m_owner = m_p; m_act = 1; m_strobe = 1; m_to = 0; m_stalls = 0;
            m_we = wev[m_p]; m_addr = addrv[m_p]; m_wdata = wdatav[m_p];
          end
        end else if (m_strobe) begin
          if (!bus_stall) m_strobe = 0;
          else begin
            m_stalls++;
`ifdef MMIO_ARB_TIMEOUT_EN
            if (m_stalls == TMO) begin m_strobe = 0; m_to = 1; end
`endif
          end
        end else m_act = 0;
      end
    end
  end

  // Master/bus drivers
  bit auto_mode = 0, rand_stall = 0, forced_stall = 0;
  int left[2] = '{0, 0};
  logic dwe[2];
  logic [14:0] daddr[2];
  logic [7:0] dwdata[2];

  task automatic step();
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      if (reqv[p] && ack_seen[p]) reqv[p] = 1'b0;
      else if (!reqv[p] && left[p] > 0) begin
        reqv[p] = 1'b1; wev[p] = dwe[p]; addrv[p] = daddr[p]; wdatav[p] = dwdata[p];
        left[p]--;
      end else if (!reqv[p] && auto_mode && $urandom_range(0, 3) == 0) begin
        reqv[p] = 1'b1; wev[p] = 1'($urandom_range(0, 1));
        addrv[p] = 15'($urandom); wdatav[p] = 8'($urandom);
      end
    end
    bus_stall = rand_stall ? ($urandom_range(0, 3) == 0) : forced_stall;
  endtask

  task automatic wait_acks(input int target, input int maxc, input string nm);
    int k = 0;
    while (alog.size() < target && k < maxc) begin step(); k++; end
    vectors++;
    if (alog.size() < target) begin
      miscompares++;
      $display("FAIL %s: %0d acks logged, %0d required within %0d cycles", nm, alog.size(), target, maxc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int b, b0, t0;

  initial begin
    reset_n = 1'b0; reqv = '0; wev = '0; addrv = '0; wdatav = '0; bus_stall = 1'b0;
    repeat (3) step();
    chk("rst_owner", owner, 1);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;

    // contention from reset: 3 reads per port, alternating
    b = alog.size();
    dwe[0] = 0; daddr[0] = 15'h0020; dwdata[0] = 0;
    dwe[1] = 0; daddr[1] = 15'h0021; dwdata[1] = 0;
    left[0] = 3; left[1] = 3;
    step(); t0 = cyc + 1;
    wait_acks(b + 6, 40, "cont_acks");
    if (alog.size() >= b + 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("cont_order", alog[b+i].p, i % 2);
        chk("cont_rdata", alog[b+i].rd, (i % 2) ? 8'hE1 : 8'hE0);
      end
      chk("cont_span", alog[b+5].c - t0, 17);
    end
    repeat (3) step();

    // single write, port 0
    b = alog.size(); we_cnt = 0;
    dwe[0] = 1; daddr[0] = 15'h0010; dwdata[0] = 8'h5A; left[0] = 1;
    step(); t0 = cyc + 1;
    wait_acks(b + 1, 10, "wr_ack");
    repeat (3) step();
    chk("wr_we_cycles", we_cnt, 1);
    chk("wr_addr", we_addr, 15'h0010);
    chk("wr_data", we_data, 8'h5A);
    chk("wr_ack_count", alog.size() - b, 1);
    if (alog.size() > b) begin
      chk("wr_ack_port", alog[b].p, 0);
      chk("wr_ack_lat", alog[b].c - t0, 2);
    end

    // single read, port 1
    b = alog.size();
    dwe[1] = 0; daddr[1] = 15'h0300; left[1] = 1;
    step();
    wait_acks(b + 1, 10, "rd_ack");
    repeat (3) step();
    if (alog.size() > b) begin
      chk("rd_port", alog[b].p, 1);
      chk("rd_data", alog[b].rd, 8'hC3);
      chk("rd_err", alog[b].er, 0);
    end

    // read with 4 stall cycles
    b = alog.size(); re_max = 0;
    dwe[0] = 0; daddr[0] = 15'h0155; left[0] = 1; forced_stall = 1;
    step(); t0 = cyc + 1;
    repeat (4) step();
    forced_stall = 0;
    wait_acks(b + 1, 10, "stall_ack");
    repeat (3) step();
    chk("stall_re_run", re_max, 5);
    if (alog.size() > b) begin
      chk("stall_lat", alog[b].c - t0, 6);
      chk("stall_data", alog[b].rd, 8'h94);
    end

`ifdef MMIO_ARB_TIMEOUT_EN
    b = alog.size(); re_max = 0;
    dwe[0] = 0; daddr[0] = 15'h0042; left[0] = 1; forced_stall = 1;
    step(); t0 = cyc + 1;
    wait_acks(b + 1, 20, "tmo_ack");
    forced_stall = 0;
    repeat (3) step();
    chk("tmo_re_run", re_max, TMO);
    if (alog.size() > b) begin
      chk("tmo_lat", alog[b].c - t0, TMO + 1);
      chk("tmo_err", alog[b].er, 1);
      chk("tmo_data", alog[b].rd, 8'hFF);
    end
    b = alog.size(); left[0] = 1;
    step();
    wait_acks(b + 1, 10, "tmo_clear_ack");
    repeat (3) step();
    if (alog.size() > b) begin
      chk("tmo_clear_err", alog[b].er, 0);
      chk("tmo_clear_data", alog[b].rd, 8'h82);
    end
`else
    b = alog.size();
    dwe[0] = 0; daddr[0] = 15'h0042; left[0] = 1; forced_stall = 1;
    repeat (20) step();
    chk("hang_busy", busy, 1);
    chk("hang_re", bus_re, 1);
    chk("hang_no_ack", alog.size() - b, 0);
    forced_stall = 0;
    wait_acks(b + 1, 10, "hang_release_ack");
    repeat (3) step();
`endif

    // reset while stalled in ISSUE
    b0 = alog.size();
    dwe[0] = 0; daddr[0] = 15'h0077; left[0] = 1; forced_stall = 1;
    repeat (3) step();
    chk("pre_rst_re", bus_re, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_re_async", bus_re, 0);
    chk("rst_busy_async", busy, 0);
    reqv = '0; forced_stall = 0;
    repeat (2) step();
    reset_n = 1'b1;
    chk("rst_owner_after", owner, 1);
    chk("rst_no_ack", alog.size() - b0, 0);
    b = alog.size();
    dwe[0] = 1; daddr[0] = 15'h0005; dwdata[0] = 8'h11;
    dwe[1] = 1; daddr[1] = 15'h0006; dwdata[1] = 8'h22;
    left[0] = 1; left[1] = 1;
    step();
    wait_acks(b + 2, 20, "rst_cont_acks");
    if (alog.size() >= b + 2) begin
      chk("rst_first_grant", alog[b].p, 0);
      chk("rst_second_grant", alog[b+1].p, 1);
    end
    repeat (3) step();

    // randomized traffic
    auto_mode = 1; rand_stall = 1;
    repeat (3000) step();
    auto_mode = 0; rand_stall = 0; forced_stall = 0;
    for (int k = 0; k < 200 && (reqv != 2'b00 || busy); k++) step();
    chk("drain_idle", {reqv, busy}, 3'b000);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Two-port arbiter that shares the single memory-mapped peripheral bus (re/we/addr/data_write/data_read, peripherals at 0x8000-0x84ff) between the CPU data port (port 0) and a secondary master such as a DMA or debug port (port 1). It serialises one transaction at a time, absorbs peripheral stall, captures the peripheral bus's one-cycle-latched read data, and returns a per-port acknowledge. It sits between the masters and the peripheral bus, in the 100 MHz `clk` domain.

## Interface
- `ADDR_W`, 15: peripheral address width, offset within 0x8000 window
- `DATA_W`, 8: data width
- `TIMEOUT`, 255: max stall cycles before abort; used only with the timeout build option, legal 1..65535

- `clk`  in  1  system clock, 100 MHz
- `reset_n`  in  1  reset, asynchronous, active-low
- `req0`, `req1`  in  1  transaction request, held until ack
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  ADDR_W  target address
- `wdata0`, `wdata1`  in  DATA_W  write data
- `ack0`, `ack1`  out  1  one-cycle completion pulse
- `rdata0`, `rdata1`  out  DATA_W  read result, valid with ack, held until next ack on that port
- `err0`, `err1`  out  1  timeout flag, valid with ack
- `bus_re`, `bus_we`  out  1  peripheral bus strobes
- `bus_addr`  out  ADDR_W  peripheral bus address
- `bus_wdata`  out  DATA_W  peripheral bus write data
- `bus_rdata`  in  DATA_W  peripheral bus read data, latched by the bus one cycle after re
- `bus_stall`  in  1  peripheral not ready; hold strobe
- `busy`  out  1  transaction in flight (state != IDLE)
- `owner`  out  1  port that owns the current or last transaction

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: sample req0/req1. If none, stay. If exactly one is set, grant it. If both are set, grant the port opposite `owner` (round-robin). Register the winner's we/addr/wdata into bus_*, set `owner`, go to ISSUE.
- ISSUE: drive bus_re = !we or bus_we = we, with bus_addr and bus_wdata stable.
  - bus_stall=1: stay in ISSUE, strobe held.
  - bus_stall=0: drop the strobe and go to RESP.
- RESP: for a read, capture bus_rdata into rdata[owner]. Pulse ack[owner], return to IDLE.
- Writes leave rdata unchanged.
- Requester rule: a master must deassert req in the cycle after it sees ack. A req still high in IDLE is a new request.
- req changes while the port is granted are ignored until IDLE; addr/we/wdata were captured at grant.
- Non-owner requests wait; their req stays pending.
- Reset values: bus_re=0, bus_we=0, bus_addr=0, bus_wdata=0, ack*=0, rdata*=0, err*=0, busy=0, owner=1, so port 0 wins the first contention.
- Reset mid-transaction: strobes drop asynchronously, no ack is issued, FSM returns to IDLE.

## Timing
- Grant latency: req seen at edge N gives the strobe in cycle N+1.
- No stall: ack in cycle N+2, IDLE in N+3. That is 3 cycles per transaction, so the sustained rate is one transaction per 3 cycles.
- Each stall cycle adds 1 cycle. The strobe stays continuously high across the stall.
- Read data: RESP samples bus_rdata in the cycle after the final strobe cycle, which matches the bus's registered read output.
- Back-to-back contention: transactions alternate 0,1,0,1 with no idle gap beyond the IDLE cycle.

## Configuration
- Macro `MMIO_ARB_TIMEOUT_EN`.
- Defined:
  - A stall counter, width $clog2(TIMEOUT+1), clears on entry to ISSUE and increments each stall cycle.
  - When the count reaches TIMEOUT while stall is still 1, the strobe drops and the FSM goes to RESP.
  - The ack carries err=1; for a read, rdata = all-ones (8'hFF).
  - err is cleared on the next ack to that port without a timeout.
- Undefined: no counter, the arbiter waits indefinitely on stall, err0/err1 are tied to 0.

## Structure
- Package `mmio_arb_pkg`: state encoding (IDLE/ISSUE/RESP), port index constants PORT_CPU=0 and PORT_AUX=1, error read value 8'hFF.
- One sub-module, `mmio_rr_pick`: combinational two-way round-robin pick from (req0, req1, owner), outputting valid and grant index. The FSM, bus registers and timeout counter stay in `mmio_arbiter`.

## Test plan
- Single write: port 0 writes 0x5A to 0x0010, no stall. Required: bus_we high for exactly 1 cycle with addr 0x0010 / wdata 0x5A, ack0 2 cycles after req, ack1 never.
- Single read: port 1 reads 0x0300, bus model returns 0xC3 one cycle after re. Required: rdata1=0xC3 with ack1, err1=0.
- Contention: req0 and req1 both high from reset, each doing 3 reads. Required: grants in order 0,1,0,1,0,1 and 6 acks in 18 cycles.
- Stall: bus_stall held 4 cycles on a port 0 read. Required: bus_re high 5 consecutive cycles, ack0 at cycle 6, correct data.
- Timeout (`MMIO_ARB_TIMEOUT_EN`, TIMEOUT=8): stall held forever. Required: strobe drops after 8 stall cycles, ack0 with err0=1 and rdata0=0xFF, next normal transaction clears err0. Without the macro, the FSM stays in ISSUE.
- Reset during ISSUE: reset_n low mid-stall. Required: bus_re=0 immediately, no ack, owner=1, first post-reset contention grants port 0.
